// File: rtl/siso_ctrl_pkg.sv
// Shared types and sizing helpers for the SISO loopback controller.
package siso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Bits needed to count 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/siso_bit_cnt.sv
// Loadable up-counter that saturates at TERM and flags the terminal count.
module siso_bit_cnt #(
  parameter int CW   = 4,
  parameter int TERM = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_reg;

  assign last = (cnt_reg == CW'(TERM));
  assign cnt  = cnt_reg;

  // Saturating at TERM keeps the counter from ever wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (en && !last) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/siso_loopback_ctrl.sv
// Serializes a word LSB-first into a SISO lane and reassembles it from the lane output.
// Optional rx-vs-tx self-check is enabled with the SISO_LOOPBACK_CHK_EN macro.
module siso_loopback_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sr_din,
  input  logic             sr_dout,
  output logic             busy,
  output logic             err
);

  localparam int CW   = cnt_width(WIDTH + DEPTH);
  localparam int TERM = WIDTH + DEPTH - 1;

  state_e           state_reg;
  state_e           state_next;
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-1:0] rx_reg;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] din_hit;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             accept;
  logic             run;

  assign run      = (state_reg == RUN);
  assign accept   = (state_reg == IDLE) && in_valid;
  assign in_ready = (state_reg == IDLE);
  assign out_valid = (state_reg == HOLD);
  assign busy     = (state_reg == RUN) || (state_reg == HOLD);
  assign out_data = rx_reg;

  siso_bit_cnt #(
    .CW   (CW),
    .TERM (TERM)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (run),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (cnt_last)  state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit gi goes out while cnt==gi and comes back DEPTH cycles later.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign din_hit[gi] = (cnt == CW'(gi)) && tx_reg[gi];
      assign rx_next[gi] = (run && (cnt == CW'(gi + DEPTH))) ? sr_dout : rx_reg[gi];
    end
  endgenerate

  assign sr_din = run && (|din_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg <= '0;
      rx_reg <= '0;
    end else begin
      if (accept) begin
        tx_reg <= in_data;
      end
      rx_reg <= rx_next;
    end
  end

`ifdef SISO_LOOPBACK_CHK_EN
  logic err_reg;

  // rx_next already holds the final captured bit on the RUN->HOLD edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (run && cnt_last && (rx_next != tx_reg)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_loopback_ctrl.sv
// Loopback bench: controller driving a behavioural DEPTH-stage SISO lane.
module tb_siso_loopback_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         sr_din;
  logic         sr_dout;
  logic         busy;
  logic         err;

  logic [D-1:0] lane;
  logic         force_one;
  logic         err_exp;
  int           checks;
  int           errors;

  siso_loopback_ctrl #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sr_din    (sr_din),
    .sr_dout   (sr_dout),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The attached lane: DEPTH flops sharing rst with the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lane <= '0;
    else     lane <= {lane[D-2:0], sr_din};
  end
  assign sr_dout = lane[D-1] | force_one;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word through the loop. Entered and left at a negedge.
  task automatic run_word(input logic [W-1:0] word, input int force_bit, input int hold_cycles,
                          input bit chain, input logic [W-1:0] chain_word, input bit expect_now);
    int waits;
    logic [W-1:0] exp_word;
    waits = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    if (expect_now) check("b2b_gap", 32'(waits), 32'd0);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 0; c < W + D; c++) begin
      @(negedge clk);
      if (c == 0) in_valid = 1'b0;
      force_one = (force_bit >= 0) && (c == D + force_bit);
      check("sr_din", 32'(sr_din), (c < W) ? 32'(word[c]) : 32'd0);
      check("run_flags", {29'd0, busy, out_valid, in_ready}, 32'b100);
    end
    @(negedge clk);
    force_one = 1'b0;
    exp_word = word;
    if (force_bit >= 0) exp_word[force_bit] = 1'b1;
`ifdef SISO_LOOPBACK_CHK_EN
    if (exp_word != word) err_exp = 1'b1;
`endif
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_data", 32'(out_data), 32'(exp_word));
    check("err", 32'(err), 32'(err_exp));
    $display("word in=%02h out=%02h err=%0d hold=%0d", word, out_data, err, hold_cycles);
    for (int h = 0; h < hold_cycles; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_data", 32'(out_data), 32'(exp_word));
      check("hold_flags", {30'd0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    if (chain) begin
      in_valid = 1'b1;
      in_data  = chain_word;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("post_flags", {29'd0, busy, out_valid, in_ready}, 32'b001);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    err_exp = 1'b0;
    force_one = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {20'd0, out_data, sr_din, busy, err, out_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_idle", {29'd0, busy, out_valid, sr_din}, 32'd0);

    run_word(8'hA5, -1, 0, 1'b0, 8'h00, 1'b0);
    run_word(8'h3C, -1, 5, 1'b0, 8'h00, 1'b0);
    run_word(8'hFF, -1, 0, 1'b1, 8'h00, 1'b0);
    run_word(8'h00, -1, 0, 1'b0, 8'h00, 1'b1);

    // Abort mid-RUN at cnt=6 with 0x81 in flight.
    in_valid = 1'b1;
    in_data  = 8'h81;
    @(posedge clk);
    for (int c = 0; c <= 6; c++) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    err_exp = 1'b0;
    #1;
    check("abort_outs", {19'd0, out_data, in_ready, sr_din, busy, err, out_valid}, 32'b1_0000);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("abort_quiet", {30'd0, out_valid, busy}, 32'd0);
    end
    $display("abort of 81 at cnt=6 done");
    run_word(8'h5A, -1, 0, 1'b0, 8'h00, 1'b0);

    run_word(8'h00, 2, 0, 1'b0, 8'h00, 1'b0);
    run_word(8'h96, -1, 1, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_word(W'($urandom_range(0, 255)), -1, int'($urandom_range(0, 3)), 1'b0, 8'h00, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/siso_loopback_ctrl.md
Name: siso_loopback_ctrl

Overview:
- Sequencer for the 4-bit serial-in/serial-out shift lane.
- Accepts a parallel word over a valid/ready handshake and drives it LSB-first into the lane's serial input.
- Samples the lane's serial output after the lane's fixed depth latency and reassembles the word.
- Returns the word over a second valid/ready handshake; used as the lane's loopback/self-test driver.

Parameters:
- WIDTH, 8, bits per transferred word (>=1).
- DEPTH, 4, stage count of the attached SISO lane (>=1); sets the serial round-trip latency.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source has a word.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to serialize.
- out_valid  output  1  reassembled word available.
- out_ready  input  1  sink accepts the word.
- out_data  output  WIDTH  reassembled word.
- sr_din  output  1  drives the lane's data_in.
- sr_dout  input  1  from the lane's data_out.
- busy  output  1  high in RUN or HOLD.
- err  output  1  sticky mismatch flag; see Optional Feature.

Behaviour:
- Reset, async on rst high: state=IDLE, cnt=0, tx/rx registers=0. Outputs: in_ready=1 after reset releases, out_valid=0, out_data=0, sr_din=0, busy=0, err=0.
- States are IDLE, RUN and HOLD.
- IDLE:
  - in_ready=1, sr_din=0.
  - On in_valid&&in_ready: latch tx=in_data, cnt=0, go to RUN.
- RUN (in_ready=0):
  - sr_din = (cnt<WIDTH) ? tx[cnt] : 0.
  - If cnt>=DEPTH, capture rx[cnt-DEPTH]=sr_dout at the edge.
  - cnt increments each cycle.
  - When cnt==WIDTH+DEPTH-1: go to HOLD on that edge, with the final capture.
- HOLD:
  - out_valid=1, out_data=rx. out_data stays stable while out_valid && !out_ready.
  - On out_ready: go to IDLE. in_ready rises the following cycle; no same-cycle accept.
- sr_din is decoded only from registered state, cnt and tx. There is no combinational path from any input to any output.
- Latency: the accept edge to out_valid rising is exactly WIDTH+DEPTH cycles.
- Minimum throughput: one word per WIDTH+DEPTH+2 cycles.
- Counter width is $clog2(WIDTH+DEPTH). Compares are unsigned, and the counter never wraps.
- Stale lane contents from before a transfer fall outside the capture window and are ignored. The lane needs no clear between words.
- in_valid in RUN or HOLD is ignored; the source holds until in_ready.
- Reset mid-RUN or mid-HOLD aborts the transfer: the word is lost, outputs return to reset values, and no out_valid is issued.
- The lane shares rst, so its contents also clear.

Optional Feature:
- Macro SISO_LOOPBACK_CHK_EN.
- Defined: on entry to HOLD, compare rx (including the final captured bit) against tx. A mismatch sets err, which stays high until rst.
- Undefined: no compare logic; err is tied to 0.

Decomposition:
- Shared package siso_ctrl_pkg holds:
  - state enum (IDLE, RUN, HOLD);
  - default WIDTH/DEPTH localparams;
  - a function for the counter width.
- Natural sub-module: siso_bit_cnt, a loadable up-counter with terminal flag at WIDTH+DEPTH-1.
- The SISO lane itself is instantiated beside the controller, not inside it.

Test Plan (WIDTH=8, DEPTH=4, real siso_shift_reg attached):
- Accept 0xA5 at cycle 0 -> out_valid rises at cycle 12 with out_data=0xA5; sr_din sequence over cycles 0..11 = 1,0,1,0,0,1,0,1,0,0,0,0; err=0.
- Hold out_ready=0 for 5 cycles in HOLD, send 0x3C -> out_data stable at 0x3C, in_ready=0 throughout; in_ready returns 1 one cycle after the out_ready handshake.
- Back-to-back 0xFF then 0x00 with in_valid held high -> outputs 0xFF then 0x00 in order; second accept exactly 1 cycle after first out handshake.
- Assert rst at RUN cnt=6 with 0x81 in flight -> out_valid never asserts; busy=0; next word 0x5A returns 0x5A.
- With SISO_LOOPBACK_CHK_EN defined, force sr_dout=1 during capture of rx[2] for 0x00 -> out_data=0x04, err=1 and stays high through the next clean word; macro undefined -> err=0.
